// File: rtl/nn_scheduler.sv
// nn_scheduler: arbitrates two requesters onto one shared nn core.
// After reset it fires a single weight-load enable pulse and idles for
// INIT_WAIT cycles. It then accepts one operand pair at a time and issues
// it to the core. It waits NN_LATENCY cycles, captures the result and holds
// it until the consumer takes it.
module nn_scheduler #(
    parameter int NN_LATENCY = 8,
    parameter int INIT_WAIT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        resp_ovf,
    output logic        resp_zero,
    output logic        nn_enable,
    output logic [31:0] nn_input_1,
    output logic [31:0] nn_input_2,
    input  logic [31:0] nn_final_output,
    input  logic        nn_total_ovf,
    input  logic        nn_total_zero,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic        last_grant;
    logic        grant_id;
    logic        handshake;

    // With both requesters valid the one not served last time wins
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign handshake = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign busy      = (state != ST_IDLE);

    // State register; reset forces INIT so the weight-load pulse repeats
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= next_state;
    end

    // Next-state logic plus the core enable and the same-cycle grants
    always_comb begin
        next_state = state;
        nn_enable  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unique case (state)
            ST_INIT: begin
                nn_enable  = 1'b1;
                next_state = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (cnt == 16'd0)
                    next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                nn_enable  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 16'd0)
                    next_state = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_INIT;
        endcase
        if (reset)
            nn_enable = 1'b0;
    end

    // Datapath: counters, operand latch, arbitration history and result capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 16'd0;
            last_grant <= 1'b1;
            nn_input_1 <= 32'd0;
            nn_input_2 <= 32'd0;
            resp_id    <= 1'b0;
            resp_data  <= 32'd0;
            resp_ovf   <= 1'b0;
            resp_zero  <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    cnt <= 16'(INIT_WAIT - 1);
                end
                ST_INIT_WAIT: begin
                    if (cnt != 16'd0)
                        cnt <= cnt - 16'd1;
                end
                ST_IDLE: begin
                    if (handshake) begin
                        last_grant <= grant_id;
                        resp_id    <= grant_id;
                        nn_input_1 <= grant_id ? req1_in1 : req0_in1;
                        nn_input_2 <= grant_id ? req1_in2 : req0_in2;
                    end
                end
                ST_ISSUE: begin
                    cnt <= 16'(NN_LATENCY - 1);
                end
                ST_WAIT: begin
                    if (cnt == 16'd0) begin
                        resp_data  <= nn_final_output;
                        resp_ovf   <= nn_total_ovf;
                        resp_zero  <= nn_total_zero;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready)
                        resp_valid <= 1'b0;
                end
                default: cnt <= 16'd0;
            endcase
        end
    end

endmodule

// File: doc/nn_scheduler.md
NN_SCHEDULER -- requirements
Module: nn_scheduler

Interface
REQ-001 Parameter NN_LATENCY, default 8, SHALL set the number of cycles from the nn enable pulse to the sampling of a valid nn result.
REQ-002 Parameter INIT_WAIT, default 3, SHALL set the number of idle cycles after the post-reset weight-load enable pulse.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1  requester n presents an input pair.
REQ-006 req0_ready / req1_ready  out  1  scheduler accepts the pair from requester n.
REQ-007 req0_in1, req0_in2, req1_in1, req1_in2  in  32  signed operand pairs.
REQ-008 resp_valid  out  1  result available; resp_ready  in  1  consumer accepts the result.
REQ-009 resp_id  out  1  index of the requester that owns the result.
REQ-010 resp_data  out  32  nn result; resp_ovf  out  1  overflow flag; resp_zero  out  1  zero flag.
REQ-011 nn_enable  out  1, nn_input_1  out  32, nn_input_2  out  32  drive the shared nn core.
REQ-012 nn_final_output  in  32, nn_total_ovf  in  1, nn_total_zero  in  1  nn core results.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL use states INIT, INIT_WAIT, IDLE, ISSUE, WAIT, RESP.
REQ-015 INIT: nn_enable=1 for exactly one cycle, then INIT_WAIT.
REQ-016 INIT_WAIT: stay INIT_WAIT cycles (counter), then IDLE; no requests accepted.
REQ-017 IDLE: if any reqn_valid=1, grant one requester and assert only its reqn_ready in that same cycle (combinational from state and valids); the handshake is valid&ready.
REQ-018 Arbitration: a single valid requester SHALL win; with both valid, the requester other than last_grant SHALL win; last_grant SHALL update on each handshake.
REQ-019 On handshake, the winner's in1/in2 SHALL be latched into nn_input_1/2 and the winner's index into resp_id; next state ISSUE.
REQ-020 nn_input_1/2 SHALL remain stable from ISSUE until the next handshake.
REQ-021 ISSUE: nn_enable=1 for exactly one cycle; next state WAIT, counter loaded to NN_LATENCY-1.
REQ-022 WAIT: decrement each cycle; at count 0, register nn_final_output, nn_total_ovf, nn_total_zero into resp_data/resp_ovf/resp_zero; next state RESP.
REQ-023 RESP: resp_valid=1; resp_data/ovf/zero/id SHALL stay stable until resp_valid&resp_ready, then IDLE.
REQ-024 Latency: for a handshake in cycle T, resp_valid SHALL first assert in cycle T+2+NN_LATENCY (T+10 by default).
REQ-025 nn_enable SHALL be 0 outside INIT and ISSUE; reqn_ready SHALL be 0 outside IDLE.
REQ-026 Back-pressure: while resp_ready=0 in RESP, no new grant occurs; pending valids SHALL stay unacknowledged without loss.
REQ-027 A new request accepted in IDLE in the same cycle RESP exits SHALL NOT occur; at least one IDLE cycle SHALL separate jobs.
REQ-028 Operands and results SHALL pass through unmodified (no width change, no sign manipulation).

Reset
REQ-029 reset=1 SHALL immediately force state INIT and zero every output register: resp_valid, resp_id, resp_data, resp_ovf, resp_zero, nn_input_1/2, counters; last_grant=1 (req0 wins first).
REQ-030 While reset=1, nn_enable, req0_ready and req1_ready SHALL be 0; busy SHALL be 1.
REQ-031 Reset mid-operation SHALL discard any in-flight job without producing a response; after release, the INIT weight-load pulse SHALL repeat.

Verification
REQ-032 Reset release -> nn_enable high exactly one cycle, readys low for 1+INIT_WAIT (4) cycles, then busy=0.
REQ-033 req0 (in1=8, in2=12), real nn core -> resp_valid at handshake+10 cycles, resp_data=0x00000032, resp_id=0, resp_ovf=0, resp_zero=0.
REQ-034 req0 and req1 both valid after reset -> req0 granted first, req1 second; resp_id order 0 then 1; next simultaneous pair -> req0 again.
REQ-035 req1 (0x7FFFFFFF, 0x7FFFFFFF) -> resp_data=0x7FFFFFFF, resp_ovf=1, resp_id=1.
REQ-036 resp_ready held low 5 cycles with req0_valid high -> response fields stable, req0_ready=0 throughout, grant only after resp handshake plus one IDLE cycle.
REQ-037 reset pulsed during WAIT -> all outputs zero within the same cycle, no resp_valid, INIT pulse reissued after release.
